// File: rtl/asrm_gpio_port.sv
// asrm_gpio_port: 16-bit GPIO peripheral on the ASRM shared system bus.
//
// Exposes a synchronised 16-bit input port (read-only) and a 16-bit output
// port (read/write) as word-wide registers. Read data is combinational and
// is forced to zero whenever the block is not selected, so it can be
// OR-combined with the other bus slaves.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   enable    chip select from the bus address decoder
//   addr      word address inside the block's window
//   write_en  CPU write strobe
//   data_in   CPU write data
//   data_out  read data (zero when deselected)
//   gpi       external inputs, asynchronous to clk
//   gpo       registered outputs
module asrm_gpio_port #(
  parameter int unsigned wordsize       = 8,
  parameter int unsigned base_addr_size = 7,
  parameter int unsigned base_addr      = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [base_addr_size-1:0] addr,
  input  logic                      write_en,
  input  logic [wordsize-1:0]       data_in,
  output logic [wordsize-1:0]       data_out,
  input  logic [15:0]               gpi,
  output logic [15:0]               gpo
);

  // Words per 16-bit port.
  localparam int unsigned NumWords = (wordsize == 8) ? 2 : 1;

  logic [15:0] gpi_meta_q, gpi_sync_q;
  logic [15:0] gpo_q, gpo_d;
  logic [31:0] addr_ext;
  logic [31:0] off;
  logic        sel;
  logic        wr;

  // Decode in 32 bits so the subtraction cannot wrap into the window.
  assign addr_ext = 32'(addr);
  assign off      = addr_ext - 32'(base_addr);
  assign sel      = enable && (addr_ext >= 32'(base_addr)) && (off < 32'(2 * NumWords));
  assign wr       = sel && write_en;

  // Two-flop synchroniser for the asynchronous inputs; runs every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpi_meta_q <= '0;
      gpi_sync_q <= '0;
    end else begin
      gpi_meta_q <= gpi;
      gpi_sync_q <= gpi_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpo_q <= '0;
    end else begin
      gpo_q <= gpo_d;
    end
  end

  assign gpo = gpo_q;

  if (wordsize == 8) begin : gen_byte_bus
    // Little-endian byte map: 0/1 gpi low/high, 2/3 gpo low/high.
    always_comb begin
      gpo_d = gpo_q;
      if (wr) begin
        if (off == 32'd2) gpo_d[7:0]  = data_in;
        if (off == 32'd3) gpo_d[15:8] = data_in;
      end
    end

    always_comb begin
      data_out = '0;
      if (sel) begin
        unique case (off[1:0])
          2'd0:    data_out = gpi_sync_q[7:0];
          2'd1:    data_out = gpi_sync_q[15:8];
          2'd2:    data_out = gpo_q[7:0];
          default: data_out = gpo_q[15:8];
        endcase
      end
    end
  end else begin : gen_wide_bus
    // Only the low 16 bits of the bus carry register data.
    logic unused_data_in;
    assign unused_data_in = ^data_in;

    always_comb begin
      gpo_d = gpo_q;
      if (wr && (off == 32'd1)) gpo_d = data_in[15:0];
    end

    always_comb begin
      data_out = '0;
      if (sel) begin
        if (off == 32'd0) data_out[15:0] = gpi_sync_q;
        else              data_out[15:0] = gpo_q;
      end
    end
  end

endmodule

// File: tb/tb_asrm_gpio_port.sv
module tb_asrm_gpio_port;

  logic        clk;
  logic        reset;
  logic        en0, en1;
  logic [6:0]  addr;
  logic        write_en;
  logic [7:0]  data_in;
  logic [15:0] gpi;
  logic [7:0]  dout0, dout1;
  logic [15:0] gpo0, gpo1;

  int n_checks = 0;
  int n_pass   = 0;

  asrm_gpio_port #(
    .wordsize      (8),
    .base_addr_size(7),
    .base_addr     (0)
  ) u_dut0 (
    .clk     (clk),
    .reset   (reset),
    .enable  (en0),
    .addr    (addr),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(dout0),
    .gpi     (gpi),
    .gpo     (gpo0)
  );

  asrm_gpio_port #(
    .wordsize      (8),
    .base_addr_size(7),
    .base_addr     (16)
  ) u_dut1 (
    .clk     (clk),
    .reset   (reset),
    .enable  (en1),
    .addr    (addr),
    .write_en(write_en),
    .data_in (data_in),
    .data_out(dout1),
    .gpi     (gpi),
    .gpo     (gpo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one bus access on the falling edge.
  task automatic bus(input logic e0, input logic e1, input logic [6:0] a, input logic we,
                     input logic [7:0] d);
    @(negedge clk);
    en0 = e0; en1 = e1; addr = a; write_en = we; data_in = d;
    #1;
  endtask

  logic [7:0] rd;

  initial begin
    reset = 1'b0; en0 = 1'b0; en1 = 1'b0; addr = '0; write_en = 1'b0; data_in = '0;
    gpi = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gpo", gpo0, 16'h0000);
    check("rst_dout_desel", {8'h00, dout0}, 16'h0000);
    en0 = 1'b1; addr = 7'd0; #1;
    check("rst_rd_off0", {8'h00, dout0}, 16'h0000);
    addr = 7'd1; #1;
    check("rst_rd_off1", {8'h00, dout0}, 16'h0000);

    @(negedge clk);
    reset = 1'b1;

    // Output write and readback.
    bus(1, 0, 7'd2, 1, 8'h5A);
    bus(1, 0, 7'd3, 1, 8'h80);
    bus(1, 0, 7'd2, 0, 8'h00);
    check("gpo_805a", gpo0, 16'h805A);
    check("rd_gpo_lo", {8'h00, dout0}, 16'h005A);
    bus(1, 0, 7'd3, 0, 8'h00);
    check("rd_gpo_hi", {8'h00, dout0}, 16'h0080);

    // Input synchroniser latency.
    bus(1, 0, 7'd0, 0, 8'h00);
    check("gpi_old", {8'h00, dout0}, 16'h0034);
    gpi = 16'hABCD;
    @(posedge clk); #1;
    check("gpi_1edge", {8'h00, dout0}, 16'h0034);
    @(posedge clk); #1;
    check("gpi_2edge", {8'h00, dout0}, 16'h00CD);
    bus(1, 0, 7'd1, 0, 8'h00);
    check("gpi_hi", {8'h00, dout0}, 16'h00AB);

    // Loop gpi low byte back to gpo low byte through the bus.
    bus(1, 0, 7'd0, 0, 8'h00);
    rd = dout0;
    bus(1, 0, 7'd2, 1, rd);
    bus(1, 0, 7'd2, 0, 8'h00);
    check("loopback", gpo0, 16'h80CD);

    // gpi offsets are read-only.
    bus(1, 0, 7'd0, 1, 8'hFF);
    bus(1, 0, 7'd0, 0, 8'h00);
    check("ro_gpi", {8'h00, dout0}, 16'h00CD);
    check("ro_gpo", gpo0, 16'h80CD);

    // Read during a write shows the pre-write value.
    bus(1, 0, 7'd2, 1, 8'h11);
    check("rd_prewrite", {8'h00, dout0}, 16'h00CD);
    @(posedge clk); #1;
    check("rd_postwrite", {8'h00, dout0}, 16'h0011);

    // Deselected access.
    bus(0, 0, 7'd2, 1, 8'h77);
    check("desel_dout", {8'h00, dout0}, 16'h0000);
    @(posedge clk); #1;
    check("desel_gpo", gpo0, 16'h8011);

    // Out-of-range offset.
    bus(1, 0, 7'd4, 1, 8'h99);
    check("oor_dout", {8'h00, dout0}, 16'h0000);
    @(posedge clk); #1;
    check("oor_gpo", gpo0, 16'h8011);

    // Nonzero base address window.
    bus(0, 1, 7'h0F, 1, 8'h55);
    check("base_below_dout", {8'h00, dout1}, 16'h0000);
    @(posedge clk); #1;
    check("base_below_gpo", gpo1, 16'h0000);
    bus(0, 1, 7'h12, 1, 8'h3C);
    bus(0, 1, 7'h12, 0, 8'h00);
    check("base_wr_gpo", gpo1, 16'h003C);
    check("base_rd_gpo", {8'h00, dout1}, 16'h003C);
    bus(0, 1, 7'h10, 0, 8'h00);
    check("base_rd_gpi", {8'h00, dout1}, 16'h00CD);
    bus(0, 1, 7'h14, 0, 8'h00);
    check("base_oor", {8'h00, dout1}, 16'h0000);
    check("base_dut0_untouched", gpo0, 16'h8011);

    // Reset in the middle of operation with a write pending.
    bus(1, 0, 7'd2, 1, 8'hFF);
    bus(1, 0, 7'd3, 1, 8'hFF);
    bus(1, 0, 7'd2, 0, 8'h00);
    check("pre_rst_gpo", gpo0, 16'hFFFF);
    bus(1, 0, 7'd2, 1, 8'h42);
    #1 reset = 1'b0;
    #1;
    check("rst_async_gpo", gpo0, 16'h0000);
    check("rst_async_dout", {8'h00, dout0}, 16'h0000);
    @(posedge clk); #1;
    check("rst_held_gpo", gpo0, 16'h0000);
    @(negedge clk);
    write_en = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_release_gpo", gpo0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
